// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259 interrupt-acknowledge sequencer.
package pic_pkg;

    localparam int PIC_NUM_IR = 8;

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        ACK1,
        GAP,
        ACK2
    } pic_state_e;

    typedef struct packed {
        logic       sngl;
        logic       sp_en;
        logic [4:0] vbase;
        logic [7:0] icw3;
    } pic_cfg_t;

    function automatic logic pic_is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [2:0] pic_lvl_encode(input logic [7:0] v);
        logic [2:0] l;
        l = 3'd0;
        for (int i = 0; i < PIC_NUM_IR; i++) begin
            if (v[i]) begin
                l = 3'(i);
            end
        end
        return l;
    endfunction

    function automatic logic [7:0] pic_lvl_onehot(input logic [2:0] l);
        return 8'h01 << l;
    endfunction

    function automatic logic [7:0] pic_vector(
        input logic [4:0] base,
        input logic [2:0] l
    );
        return {base, l};
    endfunction

endpackage

// File: rtl/pic_inta_sync.sv
// INTA synchronizer: SYNC_STAGES flops plus one edge-detect flop,
// all reset to the inactive (high) level.
module pic_inta_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inta_n,
    output logic inta_fall,
    output logic inta_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   cur;

    assign cur = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n};
            prev_q <= cur;
        end
    end

    assign inta_fall = prev_q & ~cur;
    assign inta_rise = ~prev_q & cur;

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8259 INTA sequencer: INT, cascade, ISR-set strobe and vector enable.
// Define PIC_AEOI_EN to emit the automatic-EOI clear on the second INTA.
module pic_inta_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int GAP_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inta_n,
    input  logic [7:0] irr_hi,
    input  logic       sngl,
    input  logic       sp_en,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [2:0] cas_in,
    output logic [2:0] cas_out,
    output logic       cas_oe,
    output logic       int_out,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] isr_set,
    output logic       spurious,
    output logic [7:0] eoi_auto
);

    import pic_pkg::*;

    localparam logic [15:0] GAP_MAX = 16'(GAP_TIMEOUT);

    logic inta_fall;
    logic inta_rise;

    pic_inta_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .inta_n   (inta_n),
        .inta_fall(inta_fall),
        .inta_rise(inta_rise)
    );

    pic_state_e  state_q, state_d;
    pic_cfg_t    cfg_q, cfg_d;
    logic [2:0]  lvl_q, lvl_d;
    logic        spur_q, spur_d;
    logic        sel_q, sel_d;
    logic        ack_q, ack_d;
    logic [15:0] cnt_q, cnt_d;
    logic        int_q, int_d;
    logic [2:0]  cas_q, cas_d;
    logic        cas_oe_q, cas_oe_d;
    logic [7:0]  dout_q, dout_d;
    logic        doe_q, doe_d;
    logic [7:0]  isr_q, isr_d;
    logic        spstb_q, spstb_d;

    logic is_slave;
    logic responder;
    logic timeout_hit;
    logic unused_icw2;

    assign unused_icw2 = ^icw2[2:0];
    assign is_slave    = !cfg_q.sngl && !cfg_q.sp_en;
    assign responder   = cfg_q.sngl ||
                         (cfg_q.sp_en ? !cfg_q.icw3[lvl_q] : sel_q);
    assign timeout_hit = (GAP_MAX != 16'd0) &&
                         ((cnt_q + 16'd1) == GAP_MAX);

`ifdef PIC_AEOI_EN
    logic [7:0] eoi_q, eoi_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            lvl_q    <= 3'd0;
            spur_q   <= 1'b0;
            sel_q    <= 1'b0;
            ack_q    <= 1'b0;
            cnt_q    <= 16'd0;
            int_q    <= 1'b0;
            cas_q    <= 3'd0;
            cas_oe_q <= 1'b0;
            dout_q   <= 8'h00;
            doe_q    <= 1'b0;
            isr_q    <= 8'h00;
            spstb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            lvl_q    <= lvl_d;
            spur_q   <= spur_d;
            sel_q    <= sel_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
            int_q    <= int_d;
            cas_q    <= cas_d;
            cas_oe_q <= cas_oe_d;
            dout_q   <= dout_d;
            doe_q    <= doe_d;
            isr_q    <= isr_d;
            spstb_q  <= spstb_d;
        end
    end

`ifdef PIC_AEOI_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eoi_q <= 8'h00;
        end else begin
            eoi_q <= eoi_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        lvl_d    = lvl_q;
        spur_d   = spur_q;
        sel_d    = sel_q;
        ack_d    = ack_q;
        cnt_d    = cnt_q;
        int_d    = int_q;
        cas_d    = cas_q;
        cas_oe_d = cas_oe_q;
        dout_d   = dout_q;
        doe_d    = doe_q;
        isr_d    = 8'h00;
        spstb_d  = 1'b0;
`ifdef PIC_AEOI_EN
        eoi_d    = 8'h00;
`endif
        unique case (state_q)
            IDLE: begin
                if (pic_is_onehot(irr_hi)) begin
                    lvl_d       = pic_lvl_encode(irr_hi);
                    cfg_d.sngl  = sngl;
                    cfg_d.sp_en = sp_en;
                    cfg_d.vbase = icw2[7:3];
                    cfg_d.icw3  = icw3;
                    spur_d      = 1'b0;
                    sel_d       = 1'b0;
                    ack_d       = 1'b0;
                    int_d       = 1'b1;
                    state_d     = PEND;
                end
            end
            PEND: begin
                if (inta_fall) begin
                    int_d   = 1'b0;
                    state_d = ACK1;
                    // Request withdrawn before the ack: answer as level 7.
                    if (irr_hi == 8'h00) begin
                        lvl_d   = 3'd7;
                        spur_d  = 1'b1;
                        spstb_d = 1'b1;
                    end
                    if (!cfg_q.sngl && cfg_q.sp_en &&
                        cfg_q.icw3[lvl_d]) begin
                        cas_d    = lvl_d;
                        cas_oe_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_rise) begin
                    sel_d   = is_slave && (cas_in == cfg_q.icw3[2:0]);
                    ack_d   = !spur_q && (!is_slave || sel_d);
                    isr_d   = ack_d ? pic_lvl_onehot(lvl_q) : 8'h00;
                    cnt_d   = 16'd0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (inta_fall) begin
                    dout_d  = pic_vector(cfg_q.vbase, lvl_q);
                    doe_d   = responder;
                    state_d = ACK2;
                end else if (timeout_hit) begin
                    cas_oe_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    doe_d    = 1'b0;
                    cas_oe_d = 1'b0;
                    state_d  = IDLE;
`ifdef PIC_AEOI_EN
                    if (ack_q) begin
                        eoi_d = pic_lvl_onehot(lvl_q);
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cas_out  = cas_q;
    assign cas_oe   = cas_oe_q;
    assign int_out  = int_q;
    assign data_out = dout_q;
    assign data_oe  = doe_q;
    assign isr_set  = isr_q;
    assign spurious = spstb_q;
`ifdef PIC_AEOI_EN
    assign eoi_auto = eoi_q;
`else
    assign eoi_auto = 8'h00;
`endif

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Bench for pic_inta_sequencer: directed and randomized INTA
// sequences against a transaction-level reference model.
module tb_pic_inta_sequencer;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       inta_n = 1'b1;
    logic [7:0] irr_hi = 8'h00;
    logic       sngl   = 1'b0;
    logic       sp_en  = 1'b0;
    logic [7:0] icw2   = 8'h00;
    logic [7:0] icw3   = 8'h00;
    logic [2:0] cas_in = 3'd0;
    logic [2:0] cas_out;
    logic       cas_oe;
    logic       int_out;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] isr_set;
    logic       spurious;
    logic [7:0] eoi_auto;

    int         n_cmp    = 0;
    int         n_bad    = 0;
    int         isr_cyc  = 0;
    int         spur_cyc = 0;
    int         eoi_cyc  = 0;
    logic [7:0] last_vec = 8'h00;

`ifdef PIC_AEOI_EN
    localparam bit AEOI = 1'b1;
`else
    localparam bit AEOI = 1'b0;
`endif

    always #5 clk = ~clk;

    pic_inta_sequencer #(
        .SYNC_STAGES(2),
        .GAP_TIMEOUT(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inta_n  (inta_n),
        .irr_hi  (irr_hi),
        .sngl    (sngl),
        .sp_en   (sp_en),
        .icw2    (icw2),
        .icw3    (icw3),
        .cas_in  (cas_in),
        .cas_out (cas_out),
        .cas_oe  (cas_oe),
        .int_out (int_out),
        .data_out(data_out),
        .data_oe (data_oe),
        .isr_set (isr_set),
        .spurious(spurious),
        .eoi_auto(eoi_auto)
    );

    // Count strobe cycles so one-cycle width can be checked.
    always @(negedge clk) begin
        if (isr_set != 8'h00) isr_cyc++;
        if (spurious) spur_cyc++;
        if (eoi_auto != 8'h00) eoi_cyc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [2:0] ref_lvl(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        inta_n = 1'b1;
        tick(2);
        n_cmp++;
        if ({cas_out, cas_oe, int_out, data_out, data_oe,
             isr_set, spurious, eoi_auto} !== 31'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got %h want 0",
                {cas_out, cas_oe, int_out, data_out, data_oe,
                 isr_set, spurious, eoi_auto});
        end
        rst_n = 1'b1;
        tick(2);
        n_cmp++;
        if (int_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_int: got %b want 0", int_out);
        end
    endtask

    // mode: 0 single, 1 master, 2 slave
    task automatic test_txn(
        input int         mode,
        input logic [7:0] irr,
        input bit         drop,
        input logic [7:0] i2,
        input logic [7:0] i3,
        input logic [2:0] ci,
        input bit         keep_req
    );
        logic [2:0] lv;
        bit         casc, sel, ok, resp;
        logic [7:0] ex_isr, ex_vec, ex_eoi;
        int         isr0, spur0, eoi0;
        lv     = drop ? 3'd7 : ref_lvl(irr);
        casc   = (mode == 1) && i3[lv];
        sel    = (mode == 2) && (ci == i3[2:0]);
        ok     = !drop && ((mode != 2) || sel);
        resp   = (mode == 0) || ((mode == 1) && !i3[lv]) || sel;
        ex_isr = ok ? (8'h01 << lv) : 8'h00;
        ex_vec = {i2[7:3], lv};
        ex_eoi = AEOI ? ex_isr : 8'h00;
        isr0   = isr_cyc;
        spur0  = spur_cyc;
        eoi0   = eoi_cyc;

        sngl   = (mode == 0);
        sp_en  = (mode == 1);
        icw2   = i2;
        icw3   = i3;
        cas_in = ci;
        irr_hi = irr;
        tick();
        n_cmp++;
        if (int_out !== 1'b1) begin
            n_bad++;
            $display("FAIL int_raise: got %b want 1", int_out);
        end

        sngl   = 1'($urandom);
        sp_en  = 1'($urandom);
        icw2   = 8'($urandom);
        icw3   = 8'($urandom);
        irr_hi = drop ? 8'h00 : (8'($urandom) | 8'h02);
        inta_n = 1'b0;
        tick(3);
        n_cmp++;
        if ({int_out, spurious, cas_oe} !== {1'b0, drop, casc}) begin
            n_bad++;
            $display("FAIL inta1_fall int/spur/cas_oe: got %b%b%b want 0%b%b",
                int_out, spurious, cas_oe, drop, casc);
        end
        if (casc) begin
            n_cmp++;
            if (cas_out !== lv) begin
                n_bad++;
                $display("FAIL cas_out: got %0d want %0d", cas_out, lv);
            end
        end

        sngl   = (mode == 0);
        sp_en  = (mode == 1);
        icw2   = i2;
        icw3   = i3;
        irr_hi = keep_req ? irr : 8'h00;
        tick($urandom_range(0, 2));
        inta_n = 1'b1;
        tick(3);
        n_cmp++;
        if (isr_set !== ex_isr) begin
            n_bad++;
            $display("FAIL isr_set: got %h want %h", isr_set, ex_isr);
        end

        inta_n = 1'b0;
        tick(3);
        n_cmp++;
        if ({data_oe, data_out, cas_oe} !== {resp, ex_vec, casc}) begin
            n_bad++;
            $display("FAIL inta2_fall oe/data/cas_oe: got %b %h %b want %b %h %b",
                data_oe, data_out, cas_oe, resp, ex_vec, casc);
        end
        last_vec = ex_vec;

        tick($urandom_range(0, 2));
        inta_n = 1'b1;
        tick(3);
        n_cmp++;
        if ({data_oe, cas_oe, int_out, eoi_auto, data_out} !==
            {3'b000, ex_eoi, ex_vec}) begin
            n_bad++;
            $display("FAIL inta2_rise oe/cas_oe/int/eoi/data: got %b%b%b %h %h want 000 %h %h",
                data_oe, cas_oe, int_out, eoi_auto, data_out, ex_eoi, ex_vec);
        end

        tick();
        n_cmp++;
        if (int_out !== keep_req) begin
            n_bad++;
            $display("FAIL int_after: got %b want %b", int_out, keep_req);
        end
        n_cmp++;
        if ({isr_cyc - isr0, spur_cyc - spur0, eoi_cyc - eoi0} !==
            {32'(ex_isr != 0), 32'(drop), 32'(ex_eoi != 0)}) begin
            n_bad++;
            $display("FAIL strobe_cycles isr/spur/eoi: got %0d %0d %0d want %0d %0d %0d",
                isr_cyc - isr0, spur_cyc - spur0, eoi_cyc - eoi0,
                int'(ex_isr != 0), int'(drop), int'(ex_eoi != 0));
        end
    endtask

    task automatic test_single();
        test_txn(0, 8'h08, 1'b0, 8'h40, 8'h00, 3'd0, 1'b0);
    endtask

    task automatic test_master();
        test_txn(1, 8'h04, 1'b0, 8'h40, 8'h04, 3'd0, 1'b0);
    endtask

    task automatic test_slave();
        test_txn(2, 8'h01, 1'b0, 8'hA8, 8'h02, 3'd1, 1'b0);
        test_txn(2, 8'h01, 1'b0, 8'hA8, 8'h02, 3'd2, 1'b0);
    endtask

    task automatic test_spurious();
        test_txn(0, 8'h10, 1'b1, 8'h40, 8'h00, 3'd0, 1'b0);
    endtask

    task automatic test_aeoi();
        test_txn(0, 8'h80, 1'b0, 8'h40, 8'h00, 3'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_txn(0, 8'h20, 1'b0, 8'h88, 8'h00, 3'd0, 1'b1);
        test_txn(0, 8'h20, 1'b0, 8'h88, 8'h00, 3'd0, 1'b0);
    endtask

    task automatic test_non_onehot();
        irr_hi = 8'h0C;
        tick(2);
        n_cmp++;
        if (int_out !== 1'b0) begin
            n_bad++;
            $display("FAIL non_onehot: got %b want 0", int_out);
        end
        irr_hi = 8'h00;
        tick();
    endtask

    task automatic test_idle_inta();
        int isr0;
        isr0   = isr_cyc;
        irr_hi = 8'h00;
        inta_n = 1'b0;
        tick(3);
        inta_n = 1'b1;
        tick(3);
        inta_n = 1'b0;
        tick(3);
        n_cmp++;
        if ({int_out, data_oe, data_out} !== {2'b00, last_vec} ||
            isr_cyc != isr0) begin
            n_bad++;
            $display("FAIL idle_inta: got %b%b %h isr %0d want 00 %h isr 0",
                int_out, data_oe, data_out, isr_cyc - isr0, last_vec);
        end
        inta_n = 1'b1;
        tick(3);
    endtask

    task automatic test_timeout();
        sngl   = 1'b0;
        sp_en  = 1'b1;
        icw2   = 8'h40;
        icw3   = 8'h04;
        irr_hi = 8'h04;
        tick();
        inta_n = 1'b0;
        tick(3);
        irr_hi = 8'h00;
        inta_n = 1'b1;
        tick(3);
        n_cmp++;
        if ({cas_oe, cas_out, isr_set} !== {1'b1, 3'd2, 8'h04}) begin
            n_bad++;
            $display("FAIL to_enter cas_oe/cas/isr: got %b %0d %h want 1 2 04",
                cas_oe, cas_out, isr_set);
        end
        tick(3);
        n_cmp++;
        if (cas_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL to_early: got %b want 1", cas_oe);
        end
        tick();
        n_cmp++;
        if (cas_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL to_expire: got %b want 0", cas_oe);
        end
        inta_n = 1'b0;
        tick(3);
        n_cmp++;
        if ({data_oe, data_out, int_out} !== {1'b0, last_vec, 1'b0}) begin
            n_bad++;
            $display("FAIL to_late_inta: got %b %h %b want 0 %h 0",
                data_oe, data_out, int_out, last_vec);
        end
        inta_n = 1'b1;
        tick(3);
    endtask

    task automatic test_reset_in_ack2();
        sngl   = 1'b1;
        sp_en  = 1'b0;
        icw2   = 8'h40;
        icw3   = 8'h00;
        irr_hi = 8'h08;
        tick();
        inta_n = 1'b0;
        tick(3);
        irr_hi = 8'h00;
        inta_n = 1'b1;
        tick(3);
        inta_n = 1'b0;
        tick(3);
        n_cmp++;
        if ({data_oe, data_out} !== {1'b1, 8'h43}) begin
            n_bad++;
            $display("FAIL ack2_pre: got %b %h want 1 43", data_oe, data_out);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cas_out, cas_oe, int_out, data_out, data_oe,
             isr_set, spurious, eoi_auto} !== 31'd0) begin
            n_bad++;
            $display("FAIL ack2_reset: got %h want 0",
                {cas_out, cas_oe, int_out, data_out, data_oe,
                 isr_set, spurious, eoi_auto});
        end
        inta_n = 1'b1;
        tick(2);
        rst_n    = 1'b1;
        last_vec = 8'h00;
        tick(2);
    endtask

    task automatic test_random();
        int         mode;
        logic [7:0] i3;
        logic [2:0] ci;
        for (int k = 0; k < 40; k++) begin
            mode = $urandom_range(0, 2);
            i3   = 8'($urandom);
            ci   = ((mode == 2) && ($urandom_range(0, 1) == 1)) ?
                   i3[2:0] : 3'($urandom);
            test_txn(mode, 8'h01 << $urandom_range(0, 7),
                     ($urandom_range(0, 4) == 0), 8'($urandom),
                     i3, ci, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_master();
        test_slave();
        test_spurious();
        test_aeoi();
        test_back_to_back();
        test_non_onehot();
        test_idle_inta();
        test_timeout();
        test_reset_in_ack2();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            n_cmp, n_bad);
        $finish;
    end

endmodule
